// File: rtl/mem_arb_pkg.sv
// Shared types and default geometry for the cache/memory arbiter.
package mem_arb_pkg;

  localparam int DEF_MEM_LATENCY     = 4;
  localparam int DEF_WORDS_PER_BLOCK = 8;
  localparam int DEF_ADDR_W          = 16;
  localparam int DEF_DATA_W          = 16;

  // Byte-offset bits within a block (16-bit words, so two bytes per word).
  localparam int BLOCK_OFFSET_BITS = $clog2(2 * DEF_WORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_I = 2'd1,
    FILL_D = 2'd2,
    STORE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_fill_sequencer.sv
// Issue and return word counters for one block fill.
module fill_sequencer
  import mem_arb_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  localparam int IDX_W = $clog2(WORDS_PER_BLOCK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mem_data_valid,
  output logic [IDX_W-1:0] issue_cnt,
  output logic             issuing,
  output logic [IDX_W-1:0] ret_cnt,
  output logic             last_ret
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  logic [IDX_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [IDX_W-1:0] ret_cnt_q, ret_cnt_d;
  logic             issuing_q, issuing_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      issuing_q   <= 1'b0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      issuing_q   <= issuing_d;
    end
  end

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    issuing_d   = issuing_q;
    if (start) begin
      // Reads begin the cycle after the grant, so start only arms the issuer.
      issuing_d   = 1'b1;
      issue_cnt_d = '0;
      ret_cnt_d   = '0;
    end else begin
      if (issuing_q) begin
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == LAST_IDX) begin
          issuing_d = 1'b0;
        end
      end
      if (mem_data_valid) begin
        ret_cnt_d = ret_cnt_q + 1'b1;
      end
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign issuing   = issuing_q;
  assign ret_cnt   = ret_cnt_q;
  assign last_ret  = (ret_cnt_q == LAST_IDX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I/D block fills and D write-through stores onto one pipelined
// memory port and steers returning words to the granted cache.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY     = DEF_MEM_LATENCY,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  localparam int IDX_W = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_fill_valid,
  output logic [IDX_W-1:0]  i_fill_offset,
  output logic              i_done,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_fill_valid,
  output logic [IDX_W-1:0]  d_fill_offset,
  output logic              d_done,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  output logic [DATA_W-1:0] fill_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_data_valid,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);
  localparam int                SETTLE_W   = $clog2(MEM_LATENCY + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(MEM_LATENCY);

  arb_state_t        state_q, state_d;
  logic              last_was_d_q, last_was_d_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [SETTLE_W-1:0] settle_q;

  logic             seq_start;
  logic             fill_rx;
  logic             in_fill;
  logic             settled;
  logic [IDX_W-1:0] issue_cnt;
  logic             issuing;
  logic [IDX_W-1:0] ret_cnt;
  logic             last_ret;

  assign in_fill = (state_q == FILL_I) || (state_q == FILL_D);
  assign settled = (settle_q == SETTLE_DONE);
  // Returns are only accepted during a fill, and never within MEM_LATENCY
  // cycles of reset, when reads issued before reset may still come back.
  assign fill_rx = mem_data_valid && in_fill && settled;

  fill_sequencer #(
    .WORDS_PER_BLOCK(WORDS_PER_BLOCK)
  ) u_seq (
    .clk           (clk),
    .rst           (rst),
    .start         (seq_start),
    .mem_data_valid(fill_rx),
    .issue_cnt     (issue_cnt),
    .issuing       (issuing),
    .ret_cnt       (ret_cnt),
    .last_ret      (last_ret)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_was_d_q <= 1'b0;
      base_q       <= '0;
      settle_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_was_d_q <= last_was_d_d;
      base_q       <= base_d;
      if (!settled) begin
        settle_q <= settle_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_was_d_d = last_was_d_q;
    base_d       = base_q;
    seq_start    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A D-side grant last time lets a waiting I miss jump the queue.
        if (i_req && last_was_d_q) begin
          state_d      = FILL_I;
          base_d       = i_addr & BLOCK_MASK;
          last_was_d_d = 1'b0;
          seq_start    = 1'b1;
        end else if (d_req) begin
          state_d      = FILL_D;
          base_d       = d_addr & BLOCK_MASK;
          last_was_d_d = 1'b1;
          seq_start    = 1'b1;
        end else if (d_wr_req) begin
          state_d      = STORE;
          last_was_d_d = 1'b1;
        end else if (i_req) begin
          state_d      = FILL_I;
          base_d       = i_addr & BLOCK_MASK;
          last_was_d_d = 1'b0;
          seq_start    = 1'b1;
        end
      end
      FILL_I, FILL_D: begin
        if (fill_rx && last_ret) begin
          state_d = IDLE;
        end
      end
      STORE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    d_wr_ack  = 1'b0;
    if (in_fill && issuing) begin
      mem_en   = 1'b1;
      mem_addr = base_q | (ADDR_W'(issue_cnt) << 1);
    end else if (state_q == STORE) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = d_wr_addr;
      mem_wdata = d_wr_data;
      d_wr_ack  = 1'b1;
    end
  end

  assign i_fill_valid  = fill_rx && (state_q == FILL_I);
  assign d_fill_valid  = fill_rx && (state_q == FILL_D);
  assign i_fill_offset = i_fill_valid ? ret_cnt : '0;
  assign d_fill_offset = d_fill_valid ? ret_cnt : '0;
  assign i_done        = i_fill_valid && last_ret;
  assign d_done        = d_fill_valid && last_ret;
  assign fill_data     = mem_data_out;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-stage pipelined memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        i_fill_valid;
  logic [2:0]  i_fill_offset;
  logic        i_done;
  logic        d_req = 1'b0;
  logic [15:0] d_addr = '0;
  logic        d_fill_valid;
  logic [2:0]  d_fill_offset;
  logic        d_done;
  logic        d_wr_req = 1'b0;
  logic [15:0] d_wr_addr = '0;
  logic [15:0] d_wr_data = '0;
  logic        d_wr_ack;
  logic [15:0] fill_data;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic        busy;

  int vecs = 0;
  int miscompares = 0;

  mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .i_req         (i_req),
    .i_addr        (i_addr),
    .i_fill_valid  (i_fill_valid),
    .i_fill_offset (i_fill_offset),
    .i_done        (i_done),
    .d_req         (d_req),
    .d_addr        (d_addr),
    .d_fill_valid  (d_fill_valid),
    .d_fill_offset (d_fill_offset),
    .d_done        (d_done),
    .d_wr_req      (d_wr_req),
    .d_wr_addr     (d_wr_addr),
    .d_wr_data     (d_wr_data),
    .d_wr_ack      (d_wr_ack),
    .fill_data     (fill_data),
    .mem_en        (mem_en),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_data_out  (mem_data_out),
    .mem_data_valid(mem_data_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Memory: read data = address ^ 5A5A, returned 4 cycles after mem_en.
  logic [3:0]  pv = '0;
  logic [15:0] pa0 = '0, pa1 = '0, pa2 = '0, pa3 = '0;
  always @(posedge clk) begin
    pv  <= {pv[2:0], mem_en & ~mem_wr};
    pa0 <= mem_addr;
    pa1 <= pa0;
    pa2 <= pa1;
    pa3 <= pa2;
  end
  assign mem_data_valid = pv[3];
  assign mem_data_out   = pa3 ^ 16'h5A5A;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on the negedge of the grant cycle; checks cycles 1..12 of a fill.
  task automatic check_fill(input bit is_d, input logic [15:0] base, input bit raise_wr);
    logic       own_v, oth_v, own_done, oth_done;
    logic [2:0] own_off;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      own_v    = is_d ? d_fill_valid : i_fill_valid;
      oth_v    = is_d ? i_fill_valid : d_fill_valid;
      own_done = is_d ? d_done : i_done;
      oth_done = is_d ? i_done : d_done;
      own_off  = is_d ? d_fill_offset : i_fill_offset;
      chk("busy", busy, 32'd1);
      chk("mem_en", mem_en, 32'(k <= 8));
      chk("mem_wr", mem_wr, 32'd0);
      if (k <= 8) chk("mem_addr", mem_addr, 32'(base) + 32'(2 * (k - 1)));
      chk("own_fill_valid", own_v, 32'(k >= 5));
      chk("other_fill_valid", oth_v, 32'd0);
      if (k >= 5) begin
        chk("fill_offset", own_off, 32'(k - 5));
        chk("fill_data", fill_data, 32'((base + 16'(2 * (k - 5))) ^ 16'h5A5A));
      end
      chk("own_done", own_done, 32'(k == 12));
      chk("other_done", oth_done, 32'd0);
      chk("d_wr_ack", d_wr_ack, 32'd0);
      if (raise_wr && k == 3) begin
        d_wr_req  = 1'b1;
        d_wr_addr = 16'h0040;
        d_wr_data = 16'hBEEF;
      end
    end
    $display("fill %s base=%h done at cycle 12", is_d ? "D" : "I", base);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 32'd0);
    chk("rst_mem_en", mem_en, 32'd0);
    chk("rst_mem_wr", mem_wr, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_i_fill_valid", i_fill_valid, 32'd0);
    chk("rst_d_fill_valid", d_fill_valid, 32'd0);
    chk("rst_i_done", i_done, 32'd0);
    chk("rst_d_done", d_done, 32'd0);
    chk("rst_d_wr_ack", d_wr_ack, 32'd0);
    $display("reset: outputs checked");
    rst = 1'b0;

    // 1: single I fill from 1236
    i_req = 1'b1; i_addr = 16'h1236;
    check_fill(1'b0, 16'h1230, 1'b0);
    i_req = 1'b0;
    @(negedge clk);
    chk("t1_idle", busy, 32'd0);

    // 2: simultaneous I and D, D first, I on the cycle after d_done
    i_req = 1'b1; i_addr = 16'h2468;
    d_req = 1'b1; d_addr = 16'h4A7C;
    check_fill(1'b1, 16'h4A70, 1'b0);
    d_req = 1'b0;
    @(negedge clk);
    chk("t2_gap_idle", busy, 32'd0);
    check_fill(1'b0, 16'h2460, 1'b0);
    i_req = 1'b0;
    @(negedge clk);

    // 3: store raised during I fill, issued after it
    i_req = 1'b1; i_addr = 16'h0102;
    check_fill(1'b0, 16'h0100, 1'b1);
    i_req = 1'b0;
    @(negedge clk);
    chk("t3_wait_idle", busy, 32'd0);
    chk("t3_wait_ack", d_wr_ack, 32'd0);
    @(negedge clk);
    chk("t3_st_en", mem_en, 32'd1);
    chk("t3_st_wr", mem_wr, 32'd1);
    chk("t3_st_addr", mem_addr, 32'h0040);
    chk("t3_st_wdata", mem_wdata, 32'hBEEF);
    chk("t3_st_ack", d_wr_ack, 32'd1);
    d_wr_req = 1'b0;
    $display("store addr=0040 data=BEEF acked");
    @(negedge clk);
    chk("t3_after_wr", mem_wr, 32'd0);
    chk("t3_after_ack", d_wr_ack, 32'd0);
    chk("t3_after_busy", busy, 32'd0);

    // 5: reset at cycle 5 of a fill; in-flight returns are discarded
    i_req = 1'b1; i_addr = 16'h3008;
    repeat (5) @(negedge clk);
    chk("t5_en_c5", mem_en, 32'd1);
    rst = 1'b1; i_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", busy, 32'd0);
    chk("t5_mem_en", mem_en, 32'd0);
    for (int c = 7; c <= 12; c++) begin
      @(negedge clk);
      chk("t5_i_fill_valid", i_fill_valid, 32'd0);
      chk("t5_d_fill_valid", d_fill_valid, 32'd0);
      chk("t5_i_done", i_done, 32'd0);
    end
    $display("reset mid-fill: returns discarded");

    // 6: top-of-memory block, no wrap
    i_req = 1'b1; i_addr = 16'hFFFB;
    check_fill(1'b0, 16'hFFF0, 1'b0);
    i_req = 1'b0;
    @(negedge clk);

    // 4: d_req held with i_req pending -> D, I, D
    d_req = 1'b1; d_addr = 16'h0812;
    i_req = 1'b1; i_addr = 16'h0C0A;
    check_fill(1'b1, 16'h0810, 1'b0);
    @(negedge clk);
    chk("t4_gap1", busy, 32'd0);
    check_fill(1'b0, 16'h0C00, 1'b0);
    i_req = 1'b0;
    @(negedge clk);
    chk("t4_gap2", busy, 32'd0);
    check_fill(1'b1, 16'h0810, 1'b0);
    d_req = 1'b0;
    @(negedge clk);
    chk("t4_end_idle", busy, 32'd0);
    @(negedge clk);
    chk("t4_stay_idle", mem_en, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
